// File: rtl/axis_pattern_gen_pkg.sv
// Shared definitions for the AXI-Stream test pattern generator: FSM state
// encoding, pattern_sel encodings and the colour-bar palette.
package axis_pattern_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PAT_COUNTER  = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_CHECKER  = 2'd3
    } pattern_e;

    localparam int NUM_BARS = 8;

    localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
    localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COLOR_RED     = 24'hFF0000;
    localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
    localparam logic [23:0] COLOR_BLACK   = 24'h000000;

    // Bar index (left to right) to RGB colour.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = COLOR_WHITE;
            3'd1:    c = COLOR_YELLOW;
            3'd2:    c = COLOR_CYAN;
            3'd3:    c = COLOR_GREEN;
            3'd4:    c = COLOR_MAGENTA;
            3'd5:    c = COLOR_RED;
            3'd6:    c = COLOR_BLUE;
            default: c = COLOR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/patgen_pixel.sv
// Combinational pixel colour for one beat: pattern, x, y and the linear
// beat index in, 32-bit AXIS word out.
module patgen_pixel
    import axis_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE = 480
) (
    input  logic [1:0]  pattern,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [31:0] linear,
    output logic [31:0] pixel
);

    localparam int BAR_W = H_ACTIVE / NUM_BARS;
    localparam logic [10:0] BARS_END = 11'(BAR_W * NUM_BARS);

    logic [2:0] bar_idx;
    logic       in_bars;
    logic       unused_y;

    // Only y[4] matters (checkerboard); the rest is deliberately ignored.
    assign unused_y = ^{y[10:5], y[3:0]};

    // Bar index by comparison against constant boundaries, avoiding a divider.
    always_comb begin
        bar_idx = 3'd0;
        in_bars = (x < BARS_END);
        for (int i = 1; i < NUM_BARS; i++) begin
            if (x >= 11'(BAR_W * i)) begin
                bar_idx = 3'(i);
            end
        end
    end

    // Pattern select; pixels past the last full bar are black.
    always_comb begin
        pixel = 32'd0;
        case (pattern_e'(pattern))
            PAT_COUNTER:  pixel = linear;
            PAT_BARS:     pixel = {8'h00, in_bars ? bar_color(bar_idx) : COLOR_BLACK};
            PAT_GRADIENT: pixel = {8'h00, x[8:1], x[8:1], x[8:1]};
            PAT_CHECKER:  pixel = {8'h00, (x[4] ^ y[4]) ? COLOR_WHITE : COLOR_BLACK};
            default:      pixel = 32'd0;
        endcase
    end

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI-Stream video test pattern source (IDLE / ACTIVE / GAP).
// All AXIS outputs come straight from flops; the next beat is computed from
// the next-state coordinates so tready=1 sustains one beat per clock.
// Handshake: a beat moves on a clock edge where tvalid & tready are both 1;
// once tvalid is raised, tvalid/tdata/tuser/tlast hold until that edge.
// Optional feature macro: PATGEN_FRAME_CNT_EN adds the 16-bit frame_cnt output.
module axis_pattern_gen
    import axis_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE   = 480,
    parameter int V_ACTIVE   = 272,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic [31:0] axis_tdata,
    output logic        axis_tvalid,
    input  logic        axis_tready,
    output logic        axis_tuser,
    output logic        axis_tlast,
    output logic        busy
`ifdef PATGEN_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST   = 11'(V_ACTIVE - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam bit          HAS_GAP  = (GAP_CYCLES > 0);

    state_e      state_q, state_d;
    pattern_e    pat_q, pat_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [31:0] lin_q, lin_d;
    logic [15:0] gap_q, gap_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tuser_q, tuser_d;
    logic        tlast_q, tlast_d;
    logic        busy_q, busy_d;
    logic        load;
    logic        drop;
    logic        start;
    logic        frame_done;
    logic [31:0] pix_data;

    // Next state, counters, and whether a fresh beat is loaded or the stream drops.
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        x_d        = x_q;
        y_d        = y_q;
        lin_d      = lin_q;
        gap_d      = gap_q;
        load       = 1'b0;
        drop       = 1'b0;
        start      = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) start = 1'b1;
            end
            ST_ACTIVE: begin
                if (tvalid_q && axis_tready) begin
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        frame_done = 1'b1;
                        if (HAS_GAP) begin
                            state_d = ST_GAP;
                            gap_d   = 16'd0;
                            drop    = 1'b1;
                        end else if (enable) begin
                            start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            drop    = 1'b1;
                        end
                    end else begin
                        load  = 1'b1;
                        lin_d = lin_q + 32'd1;
                        if (x_q == X_LAST) begin
                            x_d = 11'd0;
                            y_d = y_q + 11'd1;
                        end else begin
                            x_d = x_q + 11'd1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (enable) start = 1'b1;
                    else        state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Start of frame: coordinates cleared, pattern captured for the whole frame.
        if (start) begin
            state_d = ST_ACTIVE;
            pat_d   = pattern_e'(pattern_sel);
            x_d     = 11'd0;
            y_d     = 11'd0;
            lin_d   = 32'd0;
            load    = 1'b1;
        end
    end

    patgen_pixel #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pixel (
        .pattern (pat_d),
        .x       (x_d),
        .y       (y_d),
        .linear  (lin_d),
        .pixel   (pix_data)
    );

    // Output beat registers: reload on a new beat, clear on stream drop, else hold.
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        if (load) begin
            tdata_d  = pix_data;
            tvalid_d = 1'b1;
            tuser_d  = (x_d == 11'd0) && (y_d == 11'd0);
            tlast_d  = (x_d == X_LAST);
        end else if (drop) begin
            tvalid_d = 1'b0;
            tuser_d  = 1'b0;
            tlast_d  = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pat_q    <= PAT_COUNTER;
            x_q      <= 11'd0;
            y_q      <= 11'd0;
            lin_q    <= 32'd0;
            gap_q    <= 16'd0;
            tdata_q  <= 32'd0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            x_q      <= x_d;
            y_q      <= y_d;
            lin_q    <= lin_d;
            gap_q    <= gap_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
        end
    end

    assign axis_tdata  = tdata_q;
    assign axis_tvalid = tvalid_q;
    assign axis_tuser  = tuser_q;
    assign axis_tlast  = tlast_q;
    assign busy        = busy_q;

`ifdef PATGEN_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Completed-frame counter, wraps naturally at 16 bits.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_done) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (rst) frame_cnt_q <= 16'd0;
        else     frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed bench for axis_pattern_gen. Main instance uses full line width
// (480) but a short frame (12 lines) to keep run time small; a second tiny
// instance with GAP_CYCLES=0 covers back-to-back frames.
module tb_axis_pattern_gen;

    localparam int H      = 480;
    localparam int V      = 12;
    localparam int G      = 4;
    localparam int FRAME  = H * V;
    localparam int BH     = 8;
    localparam int BV     = 2;
    localparam int BFRAME = BH * BV;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        axis_tready;
    logic [31:0] axis_tdata;
    logic        axis_tvalid;
    logic        axis_tuser;
    logic        axis_tlast;
    logic        busy;

    logic        b_tready = 1'b1;
    logic [31:0] b_tdata;
    logic        b_tvalid;
    logic        b_tuser;
    logic        b_tlast;
    logic        b_busy;

`ifdef PATGEN_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] b_frame_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Clock block.
    always #5 clk = ~clk;

    axis_pattern_gen #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .GAP_CYCLES (G)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .axis_tdata  (axis_tdata),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .axis_tuser  (axis_tuser),
        .axis_tlast  (axis_tlast),
        .busy        (busy)
`ifdef PATGEN_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    axis_pattern_gen #(
        .H_ACTIVE   (BH),
        .V_ACTIVE   (BV),
        .GAP_CYCLES (0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .axis_tdata  (b_tdata),
        .axis_tvalid (b_tvalid),
        .axis_tready (b_tready),
        .axis_tuser  (b_tuser),
        .axis_tlast  (b_tlast),
        .busy        (b_busy)
`ifdef PATGEN_FRAME_CNT_EN
        ,
        .frame_cnt   (b_frame_cnt)
`endif
    );

    // Global time limit.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock and sample 1 ns after the edge.
    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        clk_step();
        clk_step();
        rst = 1'b0;
    endtask

    // Reference colour-bar table for a 480-pixel line (60-pixel bars).
    function automatic logic [31:0] exp_bar(input int x);
        logic [31:0] c;
        case (x / 60)
            0:       c = 32'h00FFFFFF;
            1:       c = 32'h00FFFF00;
            2:       c = 32'h0000FFFF;
            3:       c = 32'h0000FF00;
            4:       c = 32'h00FF00FF;
            5:       c = 32'h00FF0000;
            6:       c = 32'h000000FF;
            default: c = 32'h00000000;
        endcase
        return c;
    endfunction

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; axis_tready = 1'b1; pattern_sel = 2'd1;
        clk_step();
        clk_step();
        vectors++; if (axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b want 0", axis_tvalid); end
        vectors++; if (axis_tuser !== 1'b0) begin miscompares++; $display("FAIL reset_tuser: got %b want 0", axis_tuser); end
        vectors++; if (axis_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast: got %b want 0", axis_tlast); end
        vectors++; if (axis_tdata !== 32'd0) begin miscompares++; $display("FAIL reset_tdata: got %h want 0", axis_tdata); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0; enable = 1'b0;
        clk_step();
        vectors++; if (axis_tvalid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_hold: tvalid %b busy %b want 0 0", axis_tvalid, busy); end
    endtask

    task automatic test_counter_frame();
        int n, cyc, errs, g, gbusy;
        logic t479, last_tl;
        logic [31:0] last_td;
        do_reset();
        pattern_sel = 2'd0; axis_tready = 1'b1; enable = 1'b1;
        clk_step();
        vectors++; if (axis_tvalid !== 1'b1 || axis_tuser !== 1'b1 || axis_tdata !== 32'd0) begin miscompares++; $display("FAIL sof_beat: tvalid %b tuser %b tdata %h want 1 1 0", axis_tvalid, axis_tuser, axis_tdata); end
        n = 0; cyc = 0; errs = 0; t479 = 1'b0; last_tl = 1'b0; last_td = 32'd0;
        while (n < FRAME && cyc < FRAME + 64) begin
            if (axis_tvalid) begin
                if (axis_tdata !== 32'(n)) errs++;
                if (axis_tlast !== ((n % H) == H - 1)) errs++;
                if (axis_tuser !== (n == 0)) errs++;
                if (n == H - 1) t479 = axis_tlast;
                if (n == FRAME - 1) begin last_td = axis_tdata; last_tl = axis_tlast; end
                n++;
            end else begin
                errs++;
            end
            clk_step(); cyc++;
        end
        vectors++; if (n !== FRAME) begin miscompares++; $display("FAIL frame_beats: got %0d want %0d", n, FRAME); end
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL counter_seq: %0d bad beats want 0", errs); end
        vectors++; if (t479 !== 1'b1) begin miscompares++; $display("FAIL tlast_479: got %b want 1", t479); end
        vectors++; if (last_td !== 32'(FRAME - 1) || last_tl !== 1'b1) begin miscompares++; $display("FAIL final_beat: tdata %0d tlast %b want %0d 1", last_td, last_tl, FRAME - 1); end
        g = 0; gbusy = 0;
        while (!axis_tvalid && g < 32) begin
            if (busy !== 1'b1) gbusy++;
            g++;
            clk_step();
        end
        vectors++; if (g !== G) begin miscompares++; $display("FAIL gap_len: got %0d want %0d", g, G); end
        vectors++; if (gbusy !== 0) begin miscompares++; $display("FAIL gap_busy: %0d cycles not busy want 0", gbusy); end
        vectors++; if (axis_tvalid !== 1'b1 || axis_tdata !== 32'd0 || axis_tuser !== 1'b1) begin miscompares++; $display("FAIL next_sof: tvalid %b tdata %h tuser %b want 1 0 1", axis_tvalid, axis_tdata, axis_tuser); end
`ifdef PATGEN_FRAME_CNT_EN
        vectors++; if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL frame_cnt_one: got %0d want 1", frame_cnt); end
`endif
    endtask

    task automatic test_random_ready();
        int n, cyc, seq_errs, stall_errs, lasts;
        logic pend, p_user, p_last;
        logic [31:0] p_data;
        do_reset();
        pattern_sel = 2'd0; axis_tready = 1'b0; enable = 1'b1;
        clk_step();
        n = 0; cyc = 0; seq_errs = 0; stall_errs = 0; lasts = 0;
        pend = 1'b0; p_user = 1'b0; p_last = 1'b0; p_data = 32'd0;
        while (n < FRAME && cyc < 4 * FRAME) begin
            if (pend) begin
                if (axis_tvalid !== 1'b1 || axis_tdata !== p_data || axis_tuser !== p_user || axis_tlast !== p_last) stall_errs++;
            end
            axis_tready = 1'($urandom_range(0, 1));
            if (axis_tvalid && axis_tready) begin
                if (axis_tdata !== 32'(n)) seq_errs++;
                if (axis_tuser !== (n == 0)) seq_errs++;
                if (axis_tlast) lasts++;
                n++;
                pend = 1'b0;
            end else begin
                pend = axis_tvalid; p_data = axis_tdata; p_user = axis_tuser; p_last = axis_tlast;
            end
            clk_step(); cyc++;
        end
        axis_tready = 1'b1;
        vectors++; if (n !== FRAME) begin miscompares++; $display("FAIL rnd_beats: got %0d want %0d", n, FRAME); end
        vectors++; if (lasts !== V) begin miscompares++; $display("FAIL rnd_tlast_count: got %0d want %0d", lasts, V); end
        vectors++; if (seq_errs !== 0) begin miscompares++; $display("FAIL rnd_seq: %0d errors want 0", seq_errs); end
        vectors++; if (stall_errs !== 0) begin miscompares++; $display("FAIL rnd_stall_stable: %0d errors want 0", stall_errs); end
        vectors++; if (axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rnd_post_gap: tvalid %b want 0", axis_tvalid); end
    endtask

    task automatic test_bars();
        int n, cyc, errs, e0, e60, e479, x;
        do_reset();
        pattern_sel = 2'd1; axis_tready = 1'b1; enable = 1'b1;
        clk_step();
        n = 0; cyc = 0; errs = 0; e0 = 0; e60 = 0; e479 = 0;
        while (n < FRAME && cyc < FRAME + 64) begin
            if (axis_tvalid) begin
                x = n % H;
                if (axis_tdata !== exp_bar(x)) errs++;
                if (x == 0 && axis_tdata !== 32'h00FFFFFF) e0++;
                if (x == 60 && axis_tdata !== 32'h00FFFF00) e60++;
                if (x == 479 && axis_tdata !== 32'h00000000) e479++;
                n++;
            end
            clk_step(); cyc++;
        end
        vectors++; if (n !== FRAME) begin miscompares++; $display("FAIL bars_beats: got %0d want %0d", n, FRAME); end
        vectors++; if (e0 !== 0) begin miscompares++; $display("FAIL bars_x0: %0d lines wrong want 0", e0); end
        vectors++; if (e60 !== 0) begin miscompares++; $display("FAIL bars_x60: %0d lines wrong want 0", e60); end
        vectors++; if (e479 !== 0) begin miscompares++; $display("FAIL bars_x479: %0d lines wrong want 0", e479); end
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL bars_all: %0d pixels wrong want 0", errs); end
    endtask

    task automatic test_gradient();
        int n, errs;
        logic [31:0] exp, v256, v479;
        logic [7:0] gv;
        do_reset();
        pattern_sel = 2'd2; axis_tready = 1'b1; enable = 1'b1;
        clk_step();
        errs = 0; v256 = 32'd0; v479 = 32'd0;
        for (n = 0; n < H; n++) begin
            gv = 8'((n >> 1) & 255);
            exp = {8'h00, gv, gv, gv};
            if (axis_tvalid !== 1'b1 || axis_tdata !== exp) errs++;
            if (n == 256) v256 = axis_tdata;
            if (n == 479) v479 = axis_tdata;
            clk_step();
        end
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL grad_line: %0d pixels wrong want 0", errs); end
        vectors++; if (v256 !== 32'h00808080) begin miscompares++; $display("FAIL grad_x256: got %h want 00808080", v256); end
        vectors++; if (v479 !== 32'h00EFEFEF) begin miscompares++; $display("FAIL grad_x479: got %h want 00EFEFEF", v479); end
    endtask

    task automatic test_pattern_switch();
        int n, cyc, errs, g;
        logic [31:0] v0, v15, v16, v32;
        logic u0;
        do_reset();
        pattern_sel = 2'd0; axis_tready = 1'b1; enable = 1'b1;
        clk_step();
        n = 0; cyc = 0; errs = 0;
        while (n < FRAME && cyc < FRAME + 64) begin
            if (axis_tvalid) begin
                if (axis_tdata !== 32'(n)) errs++;
                if (n == 1000) pattern_sel = 2'd3;
                n++;
            end
            clk_step(); cyc++;
        end
        vectors++; if (n !== FRAME || errs !== 0) begin miscompares++; $display("FAIL switch_same_frame: beats %0d errors %0d want %0d 0", n, errs, FRAME); end
        g = 0;
        while (!axis_tvalid && g < 32) begin g++; clk_step(); end
        v0 = 32'hDEADBEEF; v15 = 32'hDEADBEEF; v16 = 32'hDEADBEEF; v32 = 32'hDEADBEEF; u0 = axis_tuser;
        for (int k = 0; k < 40; k++) begin
            if (k == 0)  v0  = axis_tdata;
            if (k == 15) v15 = axis_tdata;
            if (k == 16) v16 = axis_tdata;
            if (k == 32) v32 = axis_tdata;
            clk_step();
        end
        vectors++; if (u0 !== 1'b1 || v0 !== 32'h00000000) begin miscompares++; $display("FAIL chk_x0: tuser %b tdata %h want 1 00000000", u0, v0); end
        vectors++; if (v15 !== 32'h00000000) begin miscompares++; $display("FAIL chk_x15: got %h want 00000000", v15); end
        vectors++; if (v16 !== 32'h00FFFFFF) begin miscompares++; $display("FAIL chk_x16: got %h want 00FFFFFF", v16); end
        vectors++; if (v32 !== 32'h00000000) begin miscompares++; $display("FAIL chk_x32: got %h want 00000000", v32); end
    endtask

    task automatic test_enable_drop();
        int n, cyc, errs, vseen;
        logic b3, b4;
        do_reset();
        pattern_sel = 2'd0; axis_tready = 1'b1; enable = 1'b1;
        clk_step();
        n = 0; cyc = 0; errs = 0;
        while (n < FRAME && cyc < FRAME + 64) begin
            if (axis_tvalid) begin
                if (axis_tdata !== 32'(n)) errs++;
                if (n == 1000) enable = 1'b0;
                n++;
            end else begin
                errs++;
            end
            clk_step(); cyc++;
        end
        vectors++; if (n !== FRAME || errs !== 0) begin miscompares++; $display("FAIL drop_full_frame: beats %0d errors %0d want %0d 0", n, errs, FRAME); end
        vseen = 0; b3 = 1'b0; b4 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) b3 = busy;
            if (i == 4) b4 = busy;
            if (axis_tvalid) vseen++;
            clk_step();
        end
        vectors++; if (b3 !== 1'b1 || b4 !== 1'b0) begin miscompares++; $display("FAIL drop_gap_busy: gap3 %b after %b want 1 0", b3, b4); end
        vectors++; if (vseen !== 0 || axis_tvalid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL drop_idle: valid beats %0d tvalid %b busy %b want 0 0 0", vseen, axis_tvalid, busy); end
    endtask

    task automatic test_reset_mid();
        int n, cyc;
        do_reset();
        pattern_sel = 2'd0; axis_tready = 1'b1; enable = 1'b1;
        clk_step();
        n = 0; cyc = 0;
        while (n < 5000 && cyc < 6000) begin
            if (axis_tvalid) n++;
            clk_step(); cyc++;
        end
        vectors++; if (axis_tvalid !== 1'b1 || axis_tdata !== 32'd5000) begin miscompares++; $display("FAIL mid_beat5000: tvalid %b tdata %0d want 1 5000", axis_tvalid, axis_tdata); end
        rst = 1'b1;
        clk_step();
        vectors++; if (axis_tvalid !== 1'b0 || busy !== 1'b0 || axis_tuser !== 1'b0 || axis_tlast !== 1'b0 || axis_tdata !== 32'd0) begin miscompares++; $display("FAIL mid_reset: tvalid %b busy %b tuser %b tlast %b tdata %h want all 0", axis_tvalid, busy, axis_tuser, axis_tlast, axis_tdata); end
`ifdef PATGEN_FRAME_CNT_EN
        vectors++; if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_frame_cnt: got %0d want 0", frame_cnt); end
`endif
        rst = 1'b0;
        clk_step();
        vectors++; if (axis_tvalid !== 1'b1 || axis_tdata !== 32'd0 || axis_tuser !== 1'b1) begin miscompares++; $display("FAIL mid_restart_sof: tvalid %b tdata %h tuser %b want 1 0 1", axis_tvalid, axis_tdata, axis_tuser); end
    endtask

    task automatic test_back_to_back();
        int errs, e;
        logic [31:0] d15, d16;
        logic u16;
        do_reset();
        pattern_sel = 2'd0; enable = 1'b1;
        clk_step();
        errs = 0; d15 = 32'd0; d16 = 32'd0; u16 = 1'b0;
        for (int k = 0; k < 2 * BFRAME; k++) begin
            e = k % BFRAME;
            if (b_tvalid !== 1'b1 || b_tdata !== 32'(e) || b_tuser !== (e == 0) || b_tlast !== ((e % BH) == BH - 1)) errs++;
            if (k == 15) d15 = b_tdata;
            if (k == 16) begin d16 = b_tdata; u16 = b_tuser; end
            clk_step();
        end
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL b2b_stream: %0d bad beats want 0", errs); end
        vectors++; if (d15 !== 32'd15) begin miscompares++; $display("FAIL b2b_last: got %0d want 15", d15); end
        vectors++; if (d16 !== 32'd0 || u16 !== 1'b1) begin miscompares++; $display("FAIL b2b_sof: tdata %0d tuser %b want 0 1", d16, u16); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0; axis_tready = 1'b1;
        test_reset();
        test_counter_frame();
        test_random_ready();
        test_bars();
        test_gradient();
        test_pattern_switch();
        test_enable_drop();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_pattern_gen.md
AXIS_PATTERN_GEN -- requirements
Module: axis_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 272, active lines per frame.
REQ-003 SHALL have parameter GAP_CYCLES, default 4, idle cycles between frames (0 permitted).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port enable  input  1  level; start/continue frame generation.
REQ-007 SHALL have port pattern_sel  input  2  pattern choice, sampled at frame start.
REQ-008 SHALL have port axis_tdata  output  32  pixel word {8'h00, R[7:0], G[7:0], B[7:0]} (counter pattern excepted).
REQ-009 SHALL have port axis_tvalid  output  1  beat valid.
REQ-010 SHALL have port axis_tready  input  1  downstream (lcd_top) ready.
REQ-011 SHALL have port axis_tuser  output  1  start of frame, first beat only.
REQ-012 SHALL have port axis_tlast  output  1  end of line, last beat of each line.
REQ-013 SHALL have port busy  output  1  high in ACTIVE or GAP.

Function
REQ-014 SHALL implement FSM IDLE, ACTIVE, GAP; reset state IDLE.
REQ-015 IDLE -> ACTIVE when enable=1: next cycle tvalid=1, x=0, y=0, tuser=1, pattern_sel latched.
REQ-016 ACTIVE: beat transfers only when tvalid&tready; x increments per transfer, wraps at H_ACTIVE-1 with y increment.
REQ-017 Transfer of x=H_ACTIVE-1, y=V_ACTIVE-1 -> GAP (GAP_CYCLES>0) or directly next frame/IDLE (GAP_CYCLES=0).
REQ-018 GAP: tvalid=0 for exactly GAP_CYCLES cycles, then ACTIVE (new SOF) if enable=1, else IDLE.
REQ-019 Once tvalid=1, tvalid, tdata, tuser, tlast SHALL hold stable until transfer; no retraction.
REQ-020 enable=0 mid-frame SHALL NOT truncate the frame; frame completes, FSM goes IDLE after GAP.
REQ-021 pattern_sel changes mid-frame SHALL NOT take effect until next SOF.
REQ-022 tuser=1 only at x=0,y=0; tlast=1 only at x=H_ACTIVE-1 (every line).
REQ-023 Pattern 0 (counter): tdata = y*H_ACTIVE + x, zero-extended to 32 bits (0..130559 at defaults).
REQ-024 Pattern 1 (bars): 8 bars, width H_ACTIVE/8 (60); white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000; remainder pixels black.
REQ-025 Pattern 2 (gradient): R=G=B=x[8:1].
REQ-026 Pattern 3 (checker): FFFFFF when x[4]^y[4], else 000000.
REQ-027 Output registers SHALL be loaded combinationally-free: all AXIS outputs driven from flops; next beat precomputed so back-to-back transfers at tready=1 sustain one beat per clk.
REQ-028 Counters x, y SHALL be 11 bits; linear counter 32 bits, incremented per transfer, cleared at SOF (no multiplier).

Reset
REQ-029 rst=1 at any clk edge SHALL force IDLE, tvalid=0, tuser=0, tlast=0, tdata=0, busy=0, x=y=0, linear counter=0, latched pattern=0, next cycle.
REQ-030 Reset mid-frame SHALL abandon the frame; after release, next frame restarts at SOF.

Configuration
REQ-031 Macro PATGEN_FRAME_CNT_EN defined: extra port frame_cnt output 16, incremented on transfer of each frame's final beat, wraps 0xFFFF->0, reset 0.
REQ-032 Macro undefined: frame_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-033 Shared package SHALL hold pattern_sel encodings, bar colour constants, and FSM state typedef.
REQ-034 Pixel colour computation SHALL be a sub-module patgen_pixel (combinational: pattern, x, y, linear -> 24/32-bit pixel); FSM/counters in top.

Verification
REQ-035 pattern 0, tready=1, enable=1: beat0 tdata=0 tuser=1; beat479 tlast=1; beat130559 tdata=130559 tlast=1; 4 idle cycles; next beat tdata=0 tuser=1.
REQ-036 pattern 0, random tready: outputs stable during stall; exactly 130560 beats and 272 tlast per frame; tdata strictly +1 per transfer.
REQ-037 pattern 1: x=0 -> 0x00FFFFFF, x=60 -> 0x00FFFF00, x=479 -> 0x00000000, identical on every line.
REQ-038 pattern_sel 0->3 at beat 1000: remaining frame still counter; next SOF x=16,y=0 -> 0x00FFFFFF, x=0,y=0 -> 0x00000000.
REQ-039 enable=0 at beat 1000: frame completes at 130560 beats, then IDLE, tvalid=0, busy=0.
REQ-040 rst pulse at beat 5000: next cycle tvalid=0, busy=0 (frame_cnt=0 if macro set); after release, SOF beat tdata=0.
